data_memory: RTL and testbench

Word-addressed data memory (`dmem`) for the pipelined core's memory stage. It holds `DEPTH` 32-bit words. Stores are synchronous on the rising clock edge, and loads are asynchronous: combinational from the address. An asynchronous active-low reset clears the whole array to zero, so loads from unwritten locations are deterministic.

---
 rtl/data_memory.sv | 84 ++++++++
 tb/tb_data_memory.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Word-addressed data memory for the memory stage of the pipelined core.
// Holds DEPTH 32-bit words. Stores commit on the rising edge of clk; loads are
// purely combinational from the address. An asynchronous active-low reset
// clears every word, so loads from never-written locations return zero.
//
// Ports
//   clk    in   1   sole clock, writes commit on the rising edge
//   rst_n  in   1   asynchronous active-low reset, clears the whole array
//   we     in   1   write enable, sampled on the rising edge
//   a      in  32   byte address; word index is a[AW+1:2]
//   wd     in  32   write data, sampled on the rising edge when we=1
//   rd     out 32   read data, word at a[AW+1:2] (combinational)
//
// Addressing notes
//   a[1:0] is dropped: misaligned accesses hit the enclosing aligned word.
//   a[31:AW+2] is dropped: addresses past the array wrap modulo DEPTH*4.
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd
);

    // Word index shared by the write decode and the read mux.
    logic [AW-1:0] word_idx;
    assign word_idx = a[AW+1:2];

    // Address bits that intentionally play no part in the access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{a[31:AW+2], a[1:0]};

    // Current contents of every word, gathered for the read mux.
    logic [31:0] word_q_all [DEPTH];

    // One register per word. Each word owns its own decode so the write
    // path is a simple per-word load enable. Reset must clear the whole
    // array asynchronously, which is why this is a register file rather
    // than an inferred RAM.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic        wr_hit;
            logic [31:0] word_d;
            logic [31:0] word_q;

            // An X/Z on we evaluates as not-taken here, so an undriven
            // write strobe leaves the word holding its value.
            always_comb begin
                wr_hit = 1'b0;
                word_d = word_q;
                if (we && (word_idx == AW'(gi))) begin
                    wr_hit = 1'b1;
                end
                if (wr_hit) begin
                    word_d = wd;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= 32'h0000_0000;
                end else begin
                    word_q <= word_d;
                end
            end

            assign word_q_all[gi] = word_q;
        end
    endgenerate

    // Asynchronous read: no enable, no output register, no write-through.
    // During a same-address write the old word is visible until the edge.
    assign rd = word_q_all[word_idx];

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//
// Self-checking bench for data_memory. Stimulus tasks drive the ports and push
// the expected read value (from a plain array model indexed by word address
// modulo DEPTH) into a scoreboard queue; a separate monitor process pops each
// entry and compares it against rd when the stimulus signals that a read is
// being presented.
// -----------------------------------------------------------------------------
module tb_data_memory;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;

    data_memory #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory as an array of words.
    logic [31:0] model [DEPTH];

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q [$];
    event     sample_ev;

    int n_compared   = 0;
    int n_mismatched = 0;

    function automatic int widx(input logic [31:0] addr);
        return int'((addr / 32'd4) % DEPTH);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    // Present a read address, queue the model's answer and ask the monitor
    // to sample rd once the combinational path has settled.
    task automatic expect_read(input string name, input logic [31:0] addr,
                               input logic [31:0] exp);
        sb_item_t it;
        a = addr;
        #1;
        it.name = name;
        it.addr = addr;
        it.exp  = exp;
        sb_q.push_back(it);
        -> sample_ev;
        #1;
    endtask

    task automatic check_read(input string name, input logic [31:0] addr);
        expect_read(name, addr, rst_n ? model[widx(addr)] : 32'h0);
    endtask

    // One write over a single rising edge; model commits on the same edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(posedge clk);
        if (rst_n) model[widx(addr)] = data;
        #1;
        we = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a read is presented.
    initial begin
        sb_item_t it;
        forever begin
            @(sample_ev);
            if (sb_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL scoreboard_underflow: rd=%08h with nothing expected", rd);
            end else begin
                it = sb_q.pop_front();
                n_compared++;
                if (rd !== it.exp) begin
                    n_mismatched++;
                    $display("FAIL %s: a=%08h rd=%08h required=%08h",
                             it.name, it.addr, rd, it.exp);
                end else begin
                    $display("ok   %s: a=%08h rd=%08h", it.name, it.addr, rd);
                end
            end
        end
    end

    // Watchdog: the bench must never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wait_cycles;
        logic [31:0] r_addr;
        logic [31:0] r_data;

        we    = 1'b0;
        a     = 32'h0;
        wd    = 32'h0;
        rst_n = 1'b1;
        model_clear();

        // Reset then read
        #2;
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_read("reset_a0",    32'd0);
        check_read("reset_a4",    32'd4);
        check_read("reset_alast", 32'((DEPTH - 1) * 4));

        // Basic store/load
        do_write(32'd4, 32'hAA55_AA55);
        do_write(32'd8, 32'h1234_5678);
        @(negedge clk);
        expect_read("load_a4", 32'd4, 32'hAA55_AA55);
        expect_read("load_a8", 32'd8, 32'h1234_5678);
        expect_read("load_a0", 32'd0, 32'h0000_0000);

        // Write gating
        @(negedge clk);
        we = 1'b0;
        a  = 32'd12;
        wd = 32'hDEAD_BEEF;
        repeat (4) @(posedge clk);
        @(negedge clk);
        expect_read("gated_a12", 32'd12, 32'h0000_0000);

        // Alignment and aliasing
        do_write(32'd16, 32'hCAFE_F00D);
        @(negedge clk);
        expect_read("misalign_a17", 32'd17, 32'hCAFE_F00D);
        expect_read("misalign_a18", 32'd18, 32'hCAFE_F00D);
        expect_read("misalign_a19", 32'd19, 32'hCAFE_F00D);
        expect_read("alias_a16",    32'(16 + DEPTH * 4), 32'hCAFE_F00D);
        expect_read("alias_hi",     32'h8000_0010, 32'hCAFE_F00D);

        // Read-during-write at the same address
        do_write(32'd20, 32'h1111_1111);
        @(negedge clk);
        we = 1'b1;
        wd = 32'h2222_2222;
        expect_read("rdw_before", 32'd20, 32'h1111_1111);
        @(posedge clk);
        model[widx(32'd20)] = 32'h2222_2222;
        #1;
        we = 1'b0;
        expect_read("rdw_after", 32'd20, 32'h2222_2222);

        // Back-to-back writes, same address: last wins
        @(negedge clk);
        we = 1'b1; a = 32'd24; wd = 32'h0000_0001;
        @(posedge clk); #1;
        wd = 32'h0000_0002;
        @(posedge clk); #1;
        we = 1'b0;
        model[widx(32'd24)] = 32'h0000_0002;
        expect_read("b2b_last_wins", 32'd24, 32'h0000_0002);

        // Async reset mid-run, between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        expect_read("async_rst_a4",  32'd4,  32'h0000_0000);
        expect_read("async_rst_a16", 32'd16, 32'h0000_0000);
        we = 1'b1;
        a  = 32'd4;
        wd = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_read("rst_write_discarded", 32'd4, 32'h0000_0000);
        do_write(32'd4, 32'h0BAD_F00D);
        @(negedge clk);
        expect_read("first_write_after_rst", 32'd4, 32'h0BAD_F00D);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            r_addr = $urandom();
            r_data = $urandom();
            if ($urandom_range(0, 2) == 0) begin
                do_write(r_addr, r_data);
            end else begin
                @(negedge clk);
                check_read("rand_read", r_addr);
            end
        end
        // Sweep every word once at the end
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            check_read("final_sweep", 32'(i * 4 + $urandom_range(0, 3)));
        end

        // Drain the scoreboard, bounded
        wait_cycles = 0;
        while (sb_q.size() != 0 && wait_cycles < 100) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
